uart_bus_master: RTL
====================

// Module: uart_bus_master
// PURPOSE
//  Bus initiator for the UART register interface (TX=0x0, RX=0x1, FREQ_DIV=0x2).
//  Accepts one command at a time from a local valid/ready port.
//  Runs the 4-phase stb/wb_clk/ack handshake the UART slave answers and returns a one-cycle response.
//  Sits between a CPU/test sequencer and the UART; it is the initiator end of the UART's slave port.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles waited in STROBE or RELEASE before abort (1..255, 8-bit counter)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  synchronous, active-high reset
//  cmd_valid    in   1  command request
//  cmd_ready    out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
//  cmd_write    in   1  1 = register write, 0 = register read
//  cmd_addr     in   2  target register address
//  cmd_wdata    in   8  write data
//  rsp_valid    out  1  one-cycle pulse: transaction finished
//  rsp_rdata    out  8  read data; 0x00 for writes and errors
//  rsp_error    out  1  qualified by rsp_valid; 1 = timeout abort
//  busy         out  1  high in every state except IDLE
//  wb_addr      out  2  register address to slave
//  wb_wdata     out  8  write data to slave (slave wb_data_in)
//  wb_rdata     in   8  read data from slave (slave wb_data_out)
//  wb_we        out  1  0 = WRITE, 1 = READ (slave polarity)
//  wb_stb       out  1  transaction strobe
//  wb_clk       out  1  request phase qualifier
//  wb_ack       in   1  slave acknowledge
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; state IDLE; timeout counter 0. Works mid-transaction:
//   stb/wb_clk drop the cycle after reset; no rsp_valid for the aborted command.
//  All outputs registered, decoded from state (Moore). Command fields captured at acceptance.
//  wb_addr/wb_wdata/wb_we stable from SETUP through RELEASE; wb_wdata=0x00 on reads.
//  FSM:
//   IDLE:    cmd_ready=1. On cmd_valid -> SETUP.
//   SETUP:   stb=1, wb_clk=0 (one cycle of address/data setup) -> STROBE.
//   STROBE:  stb=1, wb_clk=1. On wb_ack=1: latch wb_rdata if read -> RELEASE.
//            Counter reaches TIMEOUT_CYCLES without ack -> ERROR.
//   RELEASE: stb=1, wb_clk=0. On wb_ack=0 -> DONE. Counter reaches TIMEOUT_CYCLES -> ERROR.
//   DONE:    stb=0, rsp_valid=1, rsp_error=0 -> IDLE.
//   ERROR:   stb=0, wb_clk=0, rsp_valid=1, rsp_error=1, rsp_rdata=0x00 -> IDLE.
//  Timeout counter: cleared on entry to STROBE and RELEASE; +1 per cycle in those states.
//   Saturates, never wraps.
//  Latency, acceptance cycle = 0, slave acking/releasing one cycle after sampling:
//   SETUP c1, STROBE c2-3, RELEASE c4-5, rsp_valid c6, cmd_ready again c7.
//  Back-to-back: next command accepted earliest cycle 7; cmd_valid during busy ignored, not queued.
//  wb_ack already high on entry to STROBE counts as ack (no edge detection).
//  rsp_rdata holds its value until the next rsp_valid.
// TESTING
//  Write addr0 0x55, bench slave acks 1 cycle after sampling -> wb_we=0, wb_addr=0, wb_wdata=0x55;
//   rsp_valid cycle 6, error 0, rdata 0x00.
//  Read addr1, slave returns 0xA5 -> wb_we=1, rsp_rdata=0xA5 at cycle 6, error 0.
//  TIMEOUT_CYCLES=16, slave never acks -> rsp_valid & rsp_error after 16 STROBE cycles;
//   stb=0, wb_clk=0, rdata 0x00.
//  Slave holds ack high forever -> RELEASE times out -> rsp_error=1; next command accepted afterwards.
//  cmd_valid held high with two commands -> cmd_ready low cycles 1-6; second accepted cycle 7;
//   two rsp_valid pulses.
//  Reset asserted while in STROBE -> next cycle stb=0, wb_clk=0, cmd_ready=1; no rsp_valid.

Source files
------------

// File: rtl/uart_bus_master.sv
// Bus initiator for the UART register slave: takes one command from a valid/ready port,
// runs the stb/wb_clk/ack four-phase handshake and returns a single-cycle response.
module uart_bus_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [1:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_error,
    output logic       busy,
    output logic [1:0] wb_addr,
    output logic [7:0] wb_wdata,
    input  logic [7:0] wb_rdata,
    output logic       wb_we,
    output logic       wb_stb,
    output logic       wb_clk,
    input  logic       wb_ack
);

    // Handshake: a command is taken on the cycle cmd_valid && cmd_ready are both high;
    // cmd_ready is only high in IDLE, so requests made while busy are simply not taken.

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_RELEASE = 3'd3,
        S_DONE    = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] tmo_cnt;
    logic [7:0] rdata_q;
    logic       tmo_hit;

    // Counter value k means this is the (k+1)-th cycle spent in the waiting state.
    assign tmo_hit = (tmo_cnt >= TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (cmd_valid) state_next = S_SETUP;
            S_SETUP:   state_next = S_STROBE;
            S_STROBE: begin
                if (wb_ack)       state_next = S_RELEASE;
                else if (tmo_hit) state_next = S_ERROR;
            end
            S_RELEASE: begin
                if (!wb_ack)      state_next = S_DONE;
                else if (tmo_hit) state_next = S_ERROR;
            end
            S_DONE:    state_next = S_IDLE;
            S_ERROR:   state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        wb_stb    = 1'b0;
        wb_clk    = 1'b0;
        rsp_valid = 1'b0;
        rsp_error = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            S_SETUP:   wb_stb = 1'b1;
            S_STROBE: begin
                wb_stb = 1'b1;
                wb_clk = 1'b1;
            end
            S_RELEASE: wb_stb = 1'b1;
            S_DONE:    rsp_valid = 1'b1;
            S_ERROR: begin
                rsp_valid = 1'b1;
                rsp_error = 1'b1;
            end
            default: begin
                cmd_ready = 1'b0;
                busy      = 1'b1;
            end
        endcase
    end

    // Captured command fields, timeout counter and response data.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_addr   <= 2'd0;
            wb_wdata  <= 8'h00;
            wb_we     <= 1'b0;
            tmo_cnt   <= 8'd0;
            rdata_q   <= 8'h00;
            rsp_rdata <= 8'h00;
        end else begin
            if (state == S_IDLE && cmd_valid) begin
                wb_addr  <= cmd_addr;
                wb_wdata <= cmd_write ? cmd_wdata : 8'h00;
                wb_we    <= ~cmd_write;
            end

            if ((state_next == S_STROBE || state_next == S_RELEASE) && state_next != state) begin
                tmo_cnt <= 8'd0;
            end else if ((state == S_STROBE || state == S_RELEASE) && tmo_cnt != 8'hFF) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end

            // wb_we high means a read on the slave side.
            if (state == S_STROBE && wb_ack) begin
                rdata_q <= wb_we ? wb_rdata : 8'h00;
            end

            if (state_next == S_DONE) begin
                rsp_rdata <= rdata_q;
            end else if (state_next == S_ERROR) begin
                rsp_rdata <= 8'h00;
            end
        end
    end

endmodule
